// File: rtl/gcd_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_job_sched
//  Description : Upstream job scheduler for the gcd engine. Buffers (a, b)
//                operand pairs in a small FIFO, issues them one at a time
//                with a single-cycle start pulse, resolves zero operands
//                locally, aborts a hung engine with a saturating watchdog
//                and holds each result on a valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_job_sched #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     eng_start,
    output logic [WIDTH-1:0]         eng_a,
    output logic [WIDTH-1:0]         eng_b,
    input  logic                     eng_done,
    input  logic [WIDTH-1:0]         eng_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_wd_w  = $clog2(TIMEOUT);

    localparam logic [c_ptr_w-1:0] c_ptr_one   = 1;
    localparam logic [c_ptr_w:0]   c_cnt_one   = 1;
    localparam logic [c_ptr_w:0]   c_depth_cnt = DEPTH;
    localparam logic [c_wd_w-1:0]  c_wd_one    = 1;
    localparam logic [c_wd_w-1:0]  c_wd_last   = TIMEOUT - 1;
    localparam logic [c_wd_w-1:0]  c_wd_max    = '1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_launch = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;

    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [1:0]         r_state;
    logic [c_wd_w-1:0]  r_wdog;
    logic               r_done_q;
    logic [WIDTH-1:0]   r_eng_a;
    logic [WIDTH-1:0]   r_eng_b;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_result;
    logic               r_out_err;

    logic               w_push;
    logic               w_pop;
    logic               w_out_free;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_done_edge;

    // No bypass: a full FIFO refuses input even while it is being popped.
    assign in_ready    = (r_count < c_depth_cnt);
    assign w_push      = in_valid && in_ready;
    // The output slot is free if empty or being drained this very cycle.
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_pop       = (r_state == c_st_idle) && (r_count != '0) && w_out_free;
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];
    assign w_a_zero    = (w_head_a == '0);
    assign w_b_zero    = (w_head_b == '0);
    // Only a rising done counts, so a level left high by the last job is ignored.
    assign w_done_edge = eng_done && !r_done_q;

    assign eng_start  = (r_state == c_st_launch);
    assign eng_a      = r_eng_a;
    assign eng_b      = r_eng_b;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_err    = r_out_err;
    assign fifo_count = r_count;
    assign busy       = (r_state != c_st_idle) || (r_count != '0) || r_out_valid;

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Previous-cycle copy of eng_done for edge qualification.
    always_ff @(posedge clk) begin
        if (reset) r_done_q <= 1'b0;
        else       r_done_q <= eng_done;
    end

    // Job FSM, watchdog and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_wdog       <= '0;
            r_eng_a      <= '0;
            r_eng_b      <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_err    <= 1'b0;
        end else begin
            // Consumption first; a new result written below takes priority.
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        if (w_a_zero && w_b_zero) begin
                            r_out_result <= '0;
                            r_out_err    <= 1'b1;
                            r_out_valid  <= 1'b1;
                        end else if (w_a_zero || w_b_zero) begin
                            // gcd(x, 0) = x, and the zero side contributes nothing to the OR.
                            r_out_result <= w_head_a | w_head_b;
                            r_out_err    <= 1'b0;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_eng_a <= w_head_a;
                            r_eng_b <= w_head_b;
                            r_state <= c_st_launch;
                        end
                    end
                end
                c_st_launch: begin
                    r_wdog  <= '0;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (r_wdog != c_wd_max) r_wdog <= r_wdog + c_wd_one;
                    if (w_done_edge) begin
                        r_out_result <= eng_result;
                        r_out_err    <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= c_st_idle;
                    end else if (r_wdog == c_wd_last) begin
                        r_out_result <= '0;
                        r_out_err    <= 1'b1;
                        r_out_valid  <= 1'b1;
                        r_state      <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_job_sched
//  Description : Self-checking bench for gcd_job_sched with a job-level
//                reference model, a delay-programmable engine model and
//                directed latency/boundary scenarios plus random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_job_sched;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 16;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; int d; } job_t;
    typedef struct { logic [W-1:0] r; logic e; } res_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           eng_start;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_result = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_result;
    logic           out_err;
    logic [$clog2(D):0] fifo_count;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // model / engine state
    job_t     eng_q[$];
    res_t     res_q[$];
    int       nd = 1;
    int       e_cnt = -1;
    logic     e_force = 1'b0;
    logic     e_fire;
    logic     started;
    logic [W-1:0] e_res = '0;
    int       n_starts = 0;
    logic     prev_hold = 1'b0;
    logic [W-1:0] prev_res;
    logic     prev_err;
    job_t     mon_j;
    res_t     mon_r;

    gcd_job_sched #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_result(eng_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Job-level model: every accepted pair yields one result, in order.
    // d = 0 means the engine never answers; otherwise it answers d cycles
    // after start, which is in time when d <= TO.
    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input int d);
        res_t  r;
        job_t  j;
        if (a == 0 && b == 0) begin
            r.r = '0; r.e = 1'b1;
        end else if (a == 0 || b == 0) begin
            r.r = (a == 0) ? b : a; r.e = 1'b0;
        end else begin
            j.a = a; j.b = b; j.d = d;
            eng_q.push_back(j);
            if (d == 0 || d > TO) begin r.r = '0; r.e = 1'b1; end
            else begin r.r = ref_gcd(a, b); r.e = 1'b0; end
        end
        res_q.push_back(r);
    endtask

    // Monitor + engine model, evaluated mid-cycle.
    always @(negedge clk) begin
        e_fire  = 1'b0;
        started = 1'b0;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", out_result, prev_res);
                chk("hold_err", out_err, prev_err);
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = out_result;
            prev_err  = out_err;
            if (in_valid && in_ready) model_push(in_a, in_b, nd);
            if (eng_start) begin
                n_starts++;
                started = 1'b1;
                chk("start_expected", eng_q.size() != 0, 1);
                if (eng_q.size() != 0) begin
                    mon_j = eng_q.pop_front();
                    chk("eng_a", eng_a, mon_j.a);
                    chk("eng_b", eng_b, mon_j.b);
                    e_cnt = (mon_j.d == 0) ? -1 : mon_j.d;
                    e_res = ref_gcd(mon_j.a, mon_j.b);
                end else begin
                    e_cnt = -1;
                end
            end
            if (out_valid && out_ready) begin
                chk("result_expected", res_q.size() != 0, 1);
                if (res_q.size() != 0) begin
                    mon_r = res_q.pop_front();
                    chk("out_result", out_result, mon_r.r);
                    chk("out_err", out_err, mon_r.e);
                end
            end
        end
        if (!started && e_cnt > 0) begin
            e_cnt--;
            e_fire = (e_cnt == 0);
        end
        eng_done = e_force | e_fire;
        if (e_fire) eng_result = e_res;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_eng_a"}, eng_a, 0);
        chk({tag, "_eng_b"}, eng_b, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_out_err"}, out_err, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; e_force = 1'b0; e_cnt = -1;
        cyc(); cyc();
        reset = 1'b0;
        eng_q.delete(); res_q.delete();
    endtask

    task automatic wait_out(input string tag, input logic [W-1:0] r, input logic e);
        int w = 0;
        while (!out_valid && w < 200) begin cyc(); w++; end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, r);
        chk({tag, "_err"}, out_err, e);
        cyc();
    endtask

    task automatic drain(input string tag);
        int w = 0;
        out_ready = 1'b1;
        while ((res_q.size() != 0 || busy) && w < 600) begin cyc(); w++; end
        chk({tag, "_drained"}, res_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'($urandom_range(1, 100));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic int rnd_delay();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return $urandom_range(TO + 1, TO + 4);
            default: return $urandom_range(1, TO);
        endcase
    endfunction

    initial begin
        int s0;
        int w;
        logic acc;

        do_reset();
        chk_reset_outputs("rst");

        // 1: single job, start two cycles after push, done 10 cycles after start
        out_ready = 1'b1; s0 = n_starts;
        in_valid = 1'b1; in_a = 48; in_b = 18; nd = 10;
        cyc(); in_valid = 1'b0;
        chk("t1_count", fifo_count, 1);
        chk("t1_no_start_yet", eng_start, 0);
        cyc();
        chk("t1_start", eng_start, 1);
        chk("t1_eng_a", eng_a, 48);
        chk("t1_eng_b", eng_b, 18);
        cyc();
        chk("t1_single_pulse", eng_start, 0);
        repeat (9) cyc();
        chk("t1_early", out_valid, 0);
        cyc();
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, 6);
        chk("t1_err", out_err, 0);
        cyc();
        chk("t1_consumed", out_valid, 0);
        chk("t1_one_start", n_starts - s0, 1);

        // 2: stalled engine, back-to-back pushes fill the FIFO
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = W'(100 + i); in_b = 7; nd = 0;
            chk("t2_ready", in_ready, 1);
            cyc();
        end
        in_a = 200; in_b = 9; nd = 0;
        chk("t2_full_ready", in_ready, 0);
        chk("t2_count", fifo_count, 4);
        repeat (4) begin cyc(); chk("t2_still_full", in_ready, 0); end
        w = 0;
        while (!in_ready && w < 100) begin cyc(); w++; end
        chk("t2_accept", in_ready, 1);
        cyc(); in_valid = 1'b0;
        drain("t2");

        // 3: zero operands never reach the engine
        do_reset(); out_ready = 1'b1; s0 = n_starts;
        in_valid = 1'b1; in_a = 0; in_b = 35; nd = 5;
        cyc();
        in_a = 0; in_b = 0;
        cyc(); in_valid = 1'b0;
        chk("t3_v1", out_valid, 1);
        chk("t3_r1", out_result, 35);
        chk("t3_e1", out_err, 0);
        cyc();
        chk("t3_v2", out_valid, 1);
        chk("t3_r2", out_result, 0);
        chk("t3_e2", out_err, 1);
        cyc();
        chk("t3_done", out_valid, 0);
        chk("t3_no_start", n_starts - s0, 0);

        // 4: watchdog timeout, then the queued job launches; edge/timeout boundary
        do_reset(); out_ready = 1'b1;
        in_valid = 1'b1; in_a = 7; in_b = 3; nd = 0;
        cyc();
        in_a = 9; in_b = 6; nd = 3;
        cyc(); in_valid = 1'b0;
        chk("t4_start", eng_start, 1);
        repeat (16) cyc();
        chk("t4_early", out_valid, 0);
        cyc();
        chk("t4_valid", out_valid, 1);
        chk("t4_result", out_result, 0);
        chk("t4_err", out_err, 1);
        chk("t4_no_start_yet", eng_start, 0);
        cyc();
        chk("t4_next_start", eng_start, 1);
        chk("t4_next_a", eng_a, 9);
        wait_out("t4_next", 3, 0);
        in_valid = 1'b1; in_a = 12; in_b = 8; nd = TO;
        cyc(); in_valid = 1'b0;
        wait_out("t4_edge_wins", 4, 0);
        in_valid = 1'b1; in_a = 12; in_b = 8; nd = TO + 1;
        cyc(); in_valid = 1'b0;
        wait_out("t4_late", 0, 1);

        // 5: back-pressure on the result blocks further launches
        do_reset(); out_ready = 1'b0;
        in_valid = 1'b1; in_a = 0; in_b = 5; nd = 1;
        cyc();
        in_a = 15; in_b = 10; nd = 2;
        cyc();
        in_a = 21; in_b = 14; nd = 2;
        cyc(); in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("t5_valid", out_valid, 1);
            chk("t5_result", out_result, 5);
            chk("t5_no_start", eng_start, 0);
            cyc();
        end
        out_ready = 1'b1;
        chk("t5_count", fifo_count, 2);
        chk("t5_start_not_yet", eng_start, 0);
        cyc();
        chk("t5_start", eng_start, 1);
        chk("t5_eng_a", eng_a, 15);
        drain("t5");

        // 6: stale done level, reset in WAIT, post-reset done pulse
        do_reset(); out_ready = 1'b1; e_force = 1'b1;
        in_valid = 1'b1; in_a = 40; in_b = 25; nd = 0;
        cyc(); in_valid = 1'b0;
        cyc();
        chk("t6_start", eng_start, 1);
        repeat (6) begin
            cyc();
            chk("t6_no_stale", out_valid, 0);
            chk("t6_waiting", busy, 1);
        end
        reset = 1'b1; e_force = 1'b0;
        cyc();
        reset = 1'b0; eng_q.delete(); res_q.delete();
        chk_reset_outputs("t6_rst");
        cyc(); e_force = 1'b1;
        cyc(); e_force = 1'b0;
        repeat (10) begin
            cyc();
            chk("t6_no_out", out_valid, 0);
            chk("t6_idle", busy, 0);
        end

        // Random traffic against the job-level model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op(); nd = rnd_delay();
            w = 0;
            do begin
                out_ready = ($urandom_range(0, 3) != 0);
                acc = in_ready;
                cyc();
                w++;
            end while (!acc && w < 300);
            in_valid = 1'b0;
            chk("rnd_push", acc, 1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
            end
        end
        drain("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
